// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fetch_state_t;

  localparam int PC_OFFSET = 8;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_unit_instr_fifo.sv
// Synchronous FIFO with flush; registered head, no bypass, 1-cycle push-to-visible.
// Push is dropped when full, pop ignored when empty; flush wins over both.
module instr_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  // Storage needs no reset: the head is only consumed when count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/fetch_unit.sv
// Fetch stage: one outstanding imem read, buffered to decode; ack t, rvalid t+k -> valid t+k+1.
// Issue stalls while the buffer is full; redirect flushes. FETCH_PERF_CNT_EN adds perf counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int            N          = 32,
  parameter logic [N-1:0]  RESET_PC   = '0,
  parameter int            FIFO_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  output logic         imem_req_o,
  output logic [N-1:0] imem_addr_o,
  input  logic         imem_ack_i,
  input  logic         imem_rvalid_i,
  input  logic [N-1:0] imem_rdata_i,
  input  logic         redirect_i,
  input  logic [N-1:0] redirect_pc_i,
  output logic         instr_valid_o,
  input  logic         instr_ready_i,
  output logic [N-1:0] instr_o,
  output logic [N-1:0] instr_pc_o,
  output logic [N-1:0] r15_o
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [N-1:0] perf_fetched_o,
  output logic [N-1:0] perf_stall_o
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  fetch_state_t   state, state_nx;
  logic [N-1:0]   fetch_pc, fetch_pc_nx, req_pc;
  logic           issue, xfer, push, pop;
  logic [2*N-1:0] head;
  logic [CW-1:0]  count;
  logic           full, empty;

  assign issue       = (state == REQ) && (count < CW'(FIFO_DEPTH));
  assign imem_req_o  = issue && rst_n;
  assign imem_addr_o = fetch_pc;
  assign xfer        = imem_req_o && imem_ack_i;
  // A response landing in the redirect cycle belongs to the old path.
  assign push        = (state == WAIT) && imem_rvalid_i && !redirect_i;
  assign pop         = instr_valid_o && instr_ready_i;

  always_comb begin
    state_nx    = state;
    fetch_pc_nx = fetch_pc;
    case (state)
      REQ: begin
        if (xfer) begin
          fetch_pc_nx = fetch_pc + N'(4);
          state_nx    = redirect_i ? DROP : WAIT;
        end
      end
      WAIT: begin
        if (imem_rvalid_i)   state_nx = REQ;
        else if (redirect_i) state_nx = DROP;
      end
      DROP: begin
        if (imem_rvalid_i) state_nx = REQ;
      end
      default: state_nx = REQ;
    endcase
    if (redirect_i) fetch_pc_nx = redirect_pc_i & ~N'(3);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= REQ;
      fetch_pc <= RESET_PC;
      req_pc   <= RESET_PC;
    end else begin
      state    <= state_nx;
      fetch_pc <= fetch_pc_nx;
      if (xfer) req_pc <= fetch_pc;
    end
  end

  instr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (2*N)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (redirect_i),
    .push      (push),
    .push_data ({imem_rdata_i, req_pc}),
    .pop       (pop),
    .head      (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  assign instr_valid_o = !empty;
  assign instr_o       = empty ? '0 : head[2*N-1:N];
  assign instr_pc_o    = empty ? fetch_pc : head[N-1:0];
  assign r15_o         = instr_pc_o + N'(PC_OFFSET);

`ifdef FETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetched_o <= '0;
      perf_stall_o   <= '0;
    end else begin
      if (push)           perf_fetched_o <= perf_fetched_o + N'(1);
      if (!instr_valid_o) perf_stall_o   <= perf_stall_o + N'(1);
    end
  end
`endif

`ifndef SYNTHESIS
  // Responses seen in REQ before any ack are stale traffic from before reset.
  logic armed;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    armed <= 1'b0;
    else if (xfer) armed <= 1'b1;
  end

  assert property (@(posedge clk) disable iff (!rst_n)
    !(armed && (state == REQ) && imem_rvalid_i));
  assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with a one-outstanding memory responder of programmable latency.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_ack_i;
  logic        imem_rvalid_i;
  logic [31:0] imem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic        instr_ready_i;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic [31:0] r15_o;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] perf_fetched_o;
  logic [31:0] perf_stall_o;
`endif

  fetch_unit dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_ack_i    (imem_ack_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_ready_i (instr_ready_i),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .r15_o         (r15_o)
`ifdef FETCH_PERF_CNT_EN
    ,
    .perf_fetched_o(perf_fetched_o),
    .perf_stall_o  (perf_stall_o)
`endif
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] xfer_q[$];
  logic [31:0] pop_pc_q[$];
  logic [31:0] pop_instr_q[$];
  logic        pend;
  logic [31:0] paddr;
  int          pcnt;
  int          rsp_delay;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Called just after a falling edge; records transfers/pops, then advances one cycle.
  task automatic tick();
    #1;
    if (imem_req_o && imem_ack_i) begin
      xfer_q.push_back(imem_addr_o);
      pend  = 1'b1;
      paddr = imem_addr_o;
      pcnt  = rsp_delay;
    end
    if (instr_valid_o && instr_ready_i) begin
      pop_pc_q.push_back(instr_pc_o);
      pop_instr_q.push_back(instr_o);
    end
    @(posedge clk);
    #1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    if (pend) begin
      if (pcnt <= 1) begin
        imem_rvalid_i = 1'b1;
        imem_rdata_i  = paddr ^ 32'hE000_0000;
        pend          = 1'b0;
      end else begin
        pcnt--;
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    pend          = 1'b0;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    tick();
    tick();
    xfer_q.delete();
    pop_pc_q.delete();
    pop_instr_q.delete();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %0b want 0", imem_req_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0b want 0", instr_valid_o); end
    n_checks++; if (instr_o !== 32'h0) begin n_fail++; $display("FAIL reset_instr: got %h want 00000000", instr_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 00000000", instr_pc_o); end
    n_checks++; if (r15_o !== 32'h8) begin n_fail++; $display("FAIL reset_r15: got %h want 00000008", r15_o); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (perf_fetched_o !== 32'h0) begin n_fail++; $display("FAIL reset_perf_fetched: got %h want 0", perf_fetched_o); end
    n_checks++; if (perf_stall_o !== 32'h0) begin n_fail++; $display("FAIL reset_perf_stall: got %h want 0", perf_stall_o); end
`endif
  endtask

  task automatic test_fetch_order();
    instr_ready_i = 1'b1;
    rsp_delay     = 1;
    do_reset();
    n_checks++; if (imem_req_o !== 1'b1) begin n_fail++; $display("FAIL order_first_req: got %0b want 1", imem_req_o); end
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL order_first_addr: got %h want 00000000", imem_addr_o); end
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_valid_c0: got %0b want 0", instr_valid_o); end
    tick();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL order_valid_c1: got %0b want 0", instr_valid_o); end
    tick();
    n_checks++; if (instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL order_valid_c2: got %0b want 1", instr_valid_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL order_head_pc: got %h want 00000000", instr_pc_o); end
    n_checks++; if (instr_o !== 32'hE000_0000) begin n_fail++; $display("FAIL order_head_instr: got %h want e0000000", instr_o); end
    n_checks++; if (r15_o !== 32'h8) begin n_fail++; $display("FAIL order_r15: got %h want 00000008", r15_o); end
    for (int i = 0; i < 20 && pop_pc_q.size() < 3; i++) tick();
    n_checks++; if (pop_pc_q.size() < 3) begin n_fail++; $display("FAIL order_pop_count: got %0d want 3", pop_pc_q.size()); end
    n_checks++; if (xfer_q[1] !== 32'h4) begin n_fail++; $display("FAIL order_addr1: got %h want 00000004", xfer_q[1]); end
    n_checks++; if (xfer_q[2] !== 32'h8) begin n_fail++; $display("FAIL order_addr2: got %h want 00000008", xfer_q[2]); end
    n_checks++; if (pop_pc_q[2] !== 32'h8) begin n_fail++; $display("FAIL order_pop_pc2: got %h want 00000008", pop_pc_q[2]); end
    n_checks++; if (pop_instr_q[1] !== 32'hE000_0004) begin n_fail++; $display("FAIL order_pop_instr1: got %h want e0000004", pop_instr_q[1]); end
  endtask

  task automatic test_backpressure();
    instr_ready_i = 1'b0;
    rsp_delay     = 1;
    do_reset();
    repeat (7) tick();
    n_checks++; if (xfer_q.size() !== 2) begin n_fail++; $display("FAIL bp_req_count: got %0d want 2", xfer_q.size()); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_stalled: got %0b want 0", imem_req_o); end
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL bp_head_pc: got %h want 00000000", instr_pc_o); end
    instr_ready_i = 1'b1;
    tick();
    instr_ready_i = 1'b0;
    #1;
    n_checks++; if (instr_pc_o !== 32'h4) begin n_fail++; $display("FAIL bp_head_pc_after_pop: got %h want 00000004", instr_pc_o); end
    n_checks++; if (r15_o !== 32'hC) begin n_fail++; $display("FAIL bp_r15_after_pop: got %h want 0000000c", r15_o); end
    n_checks++; if (imem_addr_o !== 32'h8) begin n_fail++; $display("FAIL bp_next_addr: got %h want 00000008", imem_addr_o); end
    repeat (5) tick();
    n_checks++; if (xfer_q.size() !== 3) begin n_fail++; $display("FAIL bp_one_per_pop: got %0d want 3", xfer_q.size()); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL bp_req_refull: got %0b want 0", imem_req_o); end
  endtask

  task automatic test_redirect_wait();
    instr_ready_i = 1'b1;
    rsp_delay     = 3;
    do_reset();
    tick();
    n_checks++; if (r15_o !== 32'hC) begin n_fail++; $display("FAIL rw_r15_wait: got %h want 0000000c", r15_o); end
    redirect_pc_i = 32'h0000_0103;
    redirect_i    = 1'b1;
    tick();
    redirect_i = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rw_drop_req: got %0b want 0", imem_req_o); end
    n_checks++; if (instr_pc_o !== 32'h100) begin n_fail++; $display("FAIL rw_empty_pc: got %h want 00000100", instr_pc_o); end
    tick();
    tick();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rw_stale_dropped: got %0b want 0", instr_valid_o); end
    n_checks++; if (imem_addr_o !== 32'h100 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rw_target_req: got req %0b addr %h want 1 00000100", imem_req_o, imem_addr_o); end
    for (int i = 0; i < 10 && !instr_valid_o; i++) tick();
    n_checks++; if (instr_pc_o !== 32'h100 || instr_valid_o !== 1'b1) begin n_fail++; $display("FAIL rw_target_pc: got valid %0b pc %h want 1 00000100", instr_valid_o, instr_pc_o); end
    n_checks++; if (r15_o !== 32'h108) begin n_fail++; $display("FAIL rw_target_r15: got %h want 00000108", r15_o); end
    n_checks++; if (instr_o !== 32'hE000_0100) begin n_fail++; $display("FAIL rw_target_instr: got %h want e0000100", instr_o); end
  endtask

  task automatic test_redirect_ack_pop();
    instr_ready_i = 1'b1;
    rsp_delay     = 1;
    do_reset();
    tick();
    tick();
    redirect_pc_i = 32'h0000_0200;
    redirect_i    = 1'b1;
    tick();
    redirect_i = 1'b0;
    #1;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rap_flushed: got %0b want 0", instr_valid_o); end
    n_checks++; if (imem_req_o !== 1'b0) begin n_fail++; $display("FAIL rap_drop_req: got %0b want 0", imem_req_o); end
    n_checks++; if (instr_pc_o !== 32'h200) begin n_fail++; $display("FAIL rap_fetch_pc: got %h want 00000200", instr_pc_o); end
    tick();
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rap_stale_dropped: got %0b want 0", instr_valid_o); end
    n_checks++; if (imem_addr_o !== 32'h200 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rap_target_req: got req %0b addr %h want 1 00000200", imem_req_o, imem_addr_o); end
    tick();
    tick();
    n_checks++; if (instr_valid_o !== 1'b1 || instr_o !== 32'hE000_0200) begin n_fail++; $display("FAIL rap_target_instr: got valid %0b instr %h want 1 e0000200", instr_valid_o, instr_o); end
  endtask

  task automatic test_pc_wrap();
    instr_ready_i = 1'b0;
    rsp_delay     = 1;
    do_reset();
    repeat (6) tick();
    redirect_pc_i = 32'hFFFF_FFFD;
    redirect_i    = 1'b1;
    tick();
    redirect_i = 1'b0;
    #1;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL wrap_flushed: got %0b want 0", instr_valid_o); end
    n_checks++; if (imem_addr_o !== 32'hFFFF_FFFC || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL wrap_req: got req %0b addr %h want 1 fffffffc", imem_req_o, imem_addr_o); end
    n_checks++; if (r15_o !== 32'h4) begin n_fail++; $display("FAIL wrap_r15_empty: got %h want 00000004", r15_o); end
    instr_ready_i = 1'b1;
    tick();
    n_checks++; if (instr_pc_o !== 32'h0) begin n_fail++; $display("FAIL wrap_fetch_pc: got %h want 00000000", instr_pc_o); end
    tick();
    n_checks++; if (instr_pc_o !== 32'hFFFF_FFFC || instr_o !== 32'h1FFF_FFFC) begin n_fail++; $display("FAIL wrap_head: got pc %h instr %h want fffffffc 1ffffffc", instr_pc_o, instr_o); end
    n_checks++; if (r15_o !== 32'h4) begin n_fail++; $display("FAIL wrap_r15_head: got %h want 00000004", r15_o); end
    n_checks++; if (imem_addr_o !== 32'h0) begin n_fail++; $display("FAIL wrap_next_addr: got %h want 00000000", imem_addr_o); end
  endtask

  task automatic test_reset_in_wait();
    instr_ready_i = 1'b1;
    rsp_delay     = 3;
    do_reset();
    repeat (5) tick();
    #1;
    n_checks++; if (r15_o !== 32'h10) begin n_fail++; $display("FAIL rst_pre_r15: got %h want 00000010", r15_o); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (imem_req_o !== 1'b0 || instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_async_ctrl: got req %0b valid %0b want 0 0", imem_req_o, instr_valid_o); end
    n_checks++; if (instr_pc_o !== 32'h0 || r15_o !== 32'h8) begin n_fail++; $display("FAIL rst_async_pc: got pc %h r15 %h want 00000000 00000008", instr_pc_o, r15_o); end
    pend          = 1'b0;
    imem_rvalid_i = 1'b0;
    tick();
    tick();
    rst_n         = 1'b1;
    imem_ack_i    = 1'b0;
    imem_rvalid_i = 1'b1;
    imem_rdata_i  = 32'hDEAD_BEEF;
    rsp_delay     = 1;
    #1;
    n_checks++; if (imem_addr_o !== 32'h0 || imem_req_o !== 1'b1) begin n_fail++; $display("FAIL rst_restart_req: got req %0b addr %h want 1 00000000", imem_req_o, imem_addr_o); end
    tick();
    imem_ack_i = 1'b1;
    #1;
    n_checks++; if (instr_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_late_rvalid_push: got %0b want 0", instr_valid_o); end
    tick();
    tick();
    n_checks++; if (instr_valid_o !== 1'b1 || instr_pc_o !== 32'h0 || instr_o !== 32'hE000_0000) begin n_fail++; $display("FAIL rst_restart_head: got valid %0b pc %h instr %h want 1 00000000 e0000000", instr_valid_o, instr_pc_o, instr_o); end
`ifdef FETCH_PERF_CNT_EN
    n_checks++; if (perf_fetched_o !== 32'h1) begin n_fail++; $display("FAIL rst_perf_fetched: got %h want 1", perf_fetched_o); end
    n_checks++; if (perf_stall_o !== 32'h3) begin n_fail++; $display("FAIL rst_perf_stall: got %h want 3", perf_stall_o); end
`endif
  endtask

  initial begin
    rst_n         = 1'b0;
    imem_ack_i    = 1'b1;
    imem_rvalid_i = 1'b0;
    imem_rdata_i  = 32'h0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'h0;
    instr_ready_i = 1'b0;
    pend          = 1'b0;
    paddr         = 32'h0;
    pcnt          = 0;
    rsp_delay     = 1;
    @(negedge clk);
    test_reset();
    test_fetch_order();
    test_backpressure();
    test_redirect_wait();
    test_redirect_ack_pop();
    test_pc_wrap();
    test_reset_in_wait();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
